// File: rtl/uart_tx_sched.sv
// UART transmit scheduler: shares one tx channel between status lines and echo.
// Status lines go out atomically; echo bytes wait in a small FIFO.
module uart_tx_sched #(
  parameter int ECHO_DEPTH = 4,
  parameter int HOLDOFF    = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        rx_data_rdy,
  input  logic [7:0]                  rx_data,
  input  logic                        echo_en,
  input  logic                        str_req,
  input  logic [7:0]                  str_data,
  input  logic                        str_last,
  output logic                        str_ack,
  input  logic                        tx_busy,
  output logic                        tx_data_rdy,
  output logic [7:0]                  tx_data,
  output logic                        line_lock,
  output logic [$clog2(ECHO_DEPTH):0] echo_cnt,
  output logic                        echo_ovf
);

  localparam int AW = $clog2(ECHO_DEPTH);
  localparam int CW = AW + 1;
  localparam int HW = (HOLDOFF < 1) ? 1 : $clog2(HOLDOFF + 1);
  localparam logic [CW-1:0] FULL = CW'(ECHO_DEPTH);
  localparam logic [HW-1:0] HLD  = HW'(HOLDOFF);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    HOLD,
    WAIT
  } state_t;

  state_t          state, state_nx;
  logic [7:0]      mem [ECHO_DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [HW-1:0]   hold_cnt, hold_nx;
  logic            sel_str, last_q, rr_str;
  logic            pick_str, pick_echo, echo_pend;
  logic            push, pop, drop;

  assign echo_pend = (echo_cnt != '0);
  assign push = rx_data_rdy & echo_en & (echo_cnt < FULL);
  assign drop = rx_data_rdy & echo_en & (echo_cnt == FULL);

  // rr_str remembers who finished last; a tie goes to the other one
  always_comb begin
    pick_str  = 1'b0;
    pick_echo = 1'b0;
    if (state == IDLE) begin
      if (line_lock) begin
        pick_str = str_req;
      end else if (str_req && echo_pend) begin
        pick_str  = ~rr_str;
        pick_echo = rr_str;
      end else begin
        pick_str  = str_req;
        pick_echo = echo_pend;
      end
    end
  end

  always_comb begin
    state_nx    = state;
    hold_nx     = hold_cnt;
    tx_data_rdy = 1'b0;
    str_ack     = 1'b0;
    pop         = 1'b0;
    unique case (state)
      IDLE: begin
        if (pick_str || pick_echo)
          state_nx = ISSUE;
      end
      ISSUE: begin
        tx_data_rdy = 1'b1;
        str_ack     = sel_str;
        pop         = ~sel_str;
        hold_nx     = HLD;
        state_nx    = (HOLDOFF == 0) ? WAIT : HOLD;
      end
      HOLD: begin
        hold_nx = hold_cnt - HW'(1);
        if (hold_cnt <= HW'(1))
          state_nx = WAIT;
      end
      WAIT: begin
        if (!tx_busy)
          state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= rx_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      hold_cnt  <= '0;
      tx_data   <= 8'h00;
      sel_str   <= 1'b0;
      last_q    <= 1'b0;
      rr_str    <= 1'b1;
      line_lock <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      echo_cnt  <= '0;
      echo_ovf  <= 1'b0;
    end else begin
      state    <= state_nx;
      hold_cnt <= hold_nx;
      if (pick_str || pick_echo) begin
        sel_str <= pick_str;
        last_q  <= str_last;
        tx_data <= pick_str ? str_data : mem[rd_ptr];
      end
      if (state == ISSUE) begin
        if (sel_str) begin
          line_lock <= ~last_q;
          if (last_q)
            rr_str <= 1'b1;
        end else begin
          rr_str <= 1'b0;
        end
      end
      if (push)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)
        echo_cnt <= echo_cnt + CW'(1);
      else if (pop && !push)
        echo_cnt <= echo_cnt - CW'(1);
      if (drop)
        echo_ovf <= 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Randomized scoreboard bench for uart_tx_sched against a timing-level model.
// Monitor pops expected tx pulses; stimulus loop checks status every cycle.
module tb_uart_tx_sched;

  localparam int DEPTH = 4;
  localparam int H     = 2;

  logic       clk = 0, rst = 1;
  logic       rx_data_rdy = 0, echo_en = 0;
  logic [7:0] rx_data = 0, str_data = 0;
  logic       str_req = 0, str_last = 0, tx_busy = 0;
  logic       str_ack, tx_data_rdy, line_lock, echo_ovf;
  logic [7:0] tx_data;
  logic [2:0] echo_cnt;

  uart_tx_sched #(.ECHO_DEPTH(DEPTH), .HOLDOFF(H)) dut (
    .clk(clk), .rst(rst),
    .rx_data_rdy(rx_data_rdy), .rx_data(rx_data),
    .echo_en(echo_en),
    .str_req(str_req), .str_data(str_data),
    .str_last(str_last), .str_ack(str_ack),
    .tx_busy(tx_busy), .tx_data_rdy(tx_data_rdy),
    .tx_data(tx_data), .line_lock(line_lock),
    .echo_cnt(echo_cnt), .echo_ovf(echo_ovf)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0, n_bad = 0;

  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               name, got, exp, cyc);
    end
  endtask

  typedef struct {
    int         cyc;
    logic [7:0] data;
    bit         is_str;
  } exp_t;

  exp_t sb[$];
  bit   mon_en = 1;

  always @(negedge clk) begin
    if (mon_en && !rst) begin
      if (tx_data_rdy) begin
        if (sb.size() == 0) begin
          chk("unexpected_pulse", tx_data_rdy, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("pulse_cycle", cyc, e.cyc);
          chk("pulse_data", tx_data, e.data);
          chk("pulse_ack", str_ack, e.is_str);
        end
      end else begin
        chk("ack_without_pulse", str_ack, 0);
        if (sb.size() != 0 && sb[0].cyc <= cyc) begin
          chk("missing_pulse", tx_data_rdy, 1);
          void'(sb.pop_front());
        end
      end
    end
  end

  string lines [4] = '{"A12:34@", "A--:--- ", "Z", "B9"};
  bit    crs   [4] = '{1, 1, 0, 1};

  function automatic int line_len(int l);
    return lines[l].len() + int'(crs[l]);
  endfunction

  function automatic logic [7:0] line_byte(int l, int p);
    if (p >= lines[l].len())
      return 8'h0d;
    return lines[l][p];
  endfunction

  // reference model: echo queue plus channel timing by cycle arithmetic
  logic [7:0] q[$];
  bit         m_ovf = 0, m_lock = 0, m_rr_echo = 0;
  logic [7:0] m_txd = 0;
  int         idle_at = 0, wait_start = 0, pend_k = -1;
  bit         waiting = 0, pend_str = 0, pend_last = 0;

  bit src_on = 0;
  int li = 0, pos = 0;

  task automatic model(int k);
    int c0;
    bit ps, pe;
    logic [7:0] b;
    c0 = q.size();
    if (!waiting && k >= idle_at) begin
      ps = str_req;
      pe = (c0 != 0);
      if (m_lock)
        pe = 0;
      else if (ps && pe) begin
        if (m_rr_echo) pe = 0;
        else ps = 0;
      end
      if (ps || pe) begin
        b = ps ? str_data : q[0];
        m_txd = b;
        sb.push_back(exp_t'{k + 1, b, ps});
        pend_k = k + 1;
        pend_str = ps;
        pend_last = str_last;
        waiting = 1;
        wait_start = k + 2 + H;
      end
    end else if (waiting && k >= wait_start && !tx_busy) begin
      waiting = 0;
      idle_at = k + 1;
    end
    if (k == pend_k) begin
      if (pend_str) begin
        m_lock = !pend_last;
        if (pend_last) m_rr_echo = 0;
      end else begin
        void'(q.pop_front());
        m_rr_echo = 1;
      end
    end
    if (rx_data_rdy && echo_en) begin
      if (c0 == DEPTH) m_ovf = 1;
      else q.push_back(rx_data);
    end
  endtask

  task automatic step(int busy_pct, int rx_pct, int req_pct);
    @(negedge clk);
    chk("echo_cnt", echo_cnt, q.size());
    chk("echo_ovf", echo_ovf, m_ovf);
    chk("line_lock", line_lock, m_lock);
    chk("tx_data_hold", tx_data, m_txd);
    if (str_ack && src_on) begin
      pos++;
      if (pos == line_len(li)) src_on = 0;
    end
    if (!src_on && int'($urandom_range(99)) < req_pct) begin
      src_on = 1;
      li = int'($urandom_range(3));
      pos = 0;
    end
    str_req = src_on && ($urandom_range(99) < 85);
    if (str_req) begin
      str_data = line_byte(li, pos);
      str_last = (pos == line_len(li) - 1);
    end else begin
      str_data = 8'($urandom);
      str_last = 1'($urandom);
    end
    rx_data_rdy = int'($urandom_range(99)) < rx_pct;
    rx_data = 8'($urandom);
    echo_en = $urandom_range(99) < 80;
    tx_busy = int'($urandom_range(99)) < busy_pct;
    model(cyc);
  endtask

  initial begin
    int t;
    repeat (3) @(negedge clk);
    chk("rst_tx_data_rdy", tx_data_rdy, 0);
    chk("rst_str_ack", str_ack, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_line_lock", line_lock, 0);
    chk("rst_echo_cnt", echo_cnt, 0);
    chk("rst_echo_ovf", echo_ovf, 0);
    rst = 0;

    repeat (2500) step(30, 15, 10);
    repeat (10) begin
      repeat (60) step(100, 25, 5);
      repeat (60) step(10, 5, 5);
    end

    t = 0;
    while ((src_on || q.size() != 0 || sb.size() != 0 || waiting)
           && t < 3000) begin
      step(20, 0, 0);
      t++;
    end
    chk("drain_timeout", t < 3000, 1);

    // a line interrupted by reset after its third byte
    src_on = 1;
    li = 0;
    pos = 0;
    t = 0;
    while (pos < 3 && t < 500) begin
      step(0, 50, 0);
      t++;
    end
    chk("line_start_timeout", t < 500, 1);
    chk("lock_mid_line", line_lock, 1);
    #2;
    mon_en = 0;
    rst = 1;
    #1;
    chk("arst_tx_data_rdy", tx_data_rdy, 0);
    chk("arst_str_ack", str_ack, 0);
    chk("arst_tx_data", tx_data, 0);
    chk("arst_line_lock", line_lock, 0);
    chk("arst_echo_cnt", echo_cnt, 0);
    chk("arst_echo_ovf", echo_ovf, 0);
    sb.delete();
    repeat (3) @(negedge clk);
    chk("held_rst_pulse", tx_data_rdy, 0);
    chk("held_rst_cnt", echo_cnt, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
